// File: rtl/my_pe_pkg.sv
// Shared types and helpers for the my_pe_fx fixed-point dot-product engine.
// The saturation helper is only referenced when PE_SATURATE_EN is defined.
package my_pe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } pe_state_t;

   // Register stages between an accept and the accumulator update.
   localparam int PIPE_DEPTH = 3;

   // Working width of the clamp helper; covers any practical ACC_W.
   localparam int SAT_W = 128;

   // Clamp a signed value into the signed range of a dw-bit word.
   function automatic logic signed [SAT_W-1:0] sat_clamp(
      input logic signed [SAT_W-1:0] v,
      input int                      dw
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (v > hi) begin
         return hi;
      end else if (v < lo) begin
         return lo;
      end else begin
         return v;
      end
   endfunction

endpackage

// File: rtl/my_pe_ram.sv
// Local weight store for my_pe_fx: one write port and one registered read port.
module my_pe_ram #(
   parameter int DW = 32,
   parameter int AW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_r [2**AW];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Registered read port; contents and read data are intentionally unreset.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem_r[raddr];
      end
   end

endmodule

// File: rtl/my_pe_fx.sv
// Signed fixed-point dot-product PE: dout = sum(ain[i]*peram[i]) + cin.
// Define PE_SATURATE_EN to clamp dout to the signed DW range instead of wrapping.
module my_pe_fx
   import my_pe_pkg::*;
#(
   parameter int DW         = 32,
   parameter int FRAC       = 8,
   parameter int L_RAM_SIZE = 6,
   parameter int ACC_W      = 48
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  we,
   input  logic [L_RAM_SIZE-1:0] waddr,
   input  logic [DW-1:0]         wdata,
   input  logic                  start,
   input  logic [L_RAM_SIZE:0]   len,
   input  logic [DW-1:0]         cin,
   input  logic [DW-1:0]         ain,
   input  logic                  ain_valid,
   output logic                  ain_ready,
   output logic                  busy,
   output logic [DW-1:0]         dout,
   output logic                  dvalid
);

   localparam int LW = L_RAM_SIZE + 1;
   localparam logic [LW-1:0]         LEN_ZERO = {LW{1'b0}};
   localparam logic [LW-1:0]         LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};
   localparam logic [L_RAM_SIZE-1:0] IDX_ZERO = {L_RAM_SIZE{1'b0}};
   localparam logic [L_RAM_SIZE-1:0] IDX_ONE  = {{(L_RAM_SIZE-1){1'b0}}, 1'b1};

   pe_state_t                state_r;
   logic [LW-1:0]            len_r;
   logic [LW-1:0]            cnt_r;
   logic [L_RAM_SIZE-1:0]    idx_r;
   logic signed [ACC_W-1:0]  acc_r;
   logic [PIPE_DEPTH-1:0]    pv_r;
   logic signed [DW-1:0]     a0_r;
   logic signed [DW-1:0]     a1_r;
   logic signed [DW-1:0]     b1_r;
   logic signed [2*DW-1:0]   prod_r;
   logic [DW-1:0]            rdata_s;
   logic                     accept_s;
   logic                     wr_en_s;
   logic signed [ACC_W-1:0]  inc_s;
   logic [DW-1:0]            result_s;
`ifdef PE_SATURATE_EN
   logic signed [SAT_W-1:0]  sat_wide_s;
`endif

   assign accept_s = ain_valid & ain_ready & (state_r == RUN);
   assign wr_en_s  = we & (state_r == IDLE);

   my_pe_ram #(
      .DW (DW),
      .AW (L_RAM_SIZE)
   ) u_ram (
      .clk   (aclk),
      .we    (wr_en_s),
      .waddr (waddr),
      .wdata (wdata),
      .re    (accept_s),
      .raddr (idx_r),
      .rdata (rdata_s)
   );

   // Scaled product and final result formatting.
   always_comb begin
      inc_s = ACC_W'(prod_r >>> FRAC);
`ifdef PE_SATURATE_EN
      sat_wide_s = sat_clamp(SAT_W'(acc_r), DW);
      result_s   = sat_wide_s[DW-1:0];
`else
      result_s   = acc_r[DW-1:0];
`endif
   end

   // Operand/product pipeline; each stage carries a valid bit so bubbles pass harmlessly.
   always_ff @(posedge aclk) begin
      if (areset) begin
         pv_r   <= {PIPE_DEPTH{1'b0}};
         a0_r   <= {DW{1'b0}};
         a1_r   <= {DW{1'b0}};
         b1_r   <= {DW{1'b0}};
         prod_r <= {(2*DW){1'b0}};
      end else begin
         pv_r   <= {pv_r[PIPE_DEPTH-2:0], accept_s};
         if (accept_s) begin
            a0_r <= ain;
         end
         a1_r   <= a0_r;
         b1_r   <= rdata_s;
         prod_r <= (2*DW)'(a1_r) * (2*DW)'(b1_r);
      end
   end

   // Control FSM, accumulator and registered outputs.
   always_ff @(posedge aclk) begin
      if (areset) begin
         state_r   <= IDLE;
         len_r     <= LEN_ZERO;
         cnt_r     <= LEN_ZERO;
         idx_r     <= IDX_ZERO;
         acc_r     <= {ACC_W{1'b0}};
         ain_ready <= 1'b0;
         busy      <= 1'b0;
         dout      <= {DW{1'b0}};
         dvalid    <= 1'b0;
      end else begin
         dvalid <= 1'b0;
         if (pv_r[PIPE_DEPTH-1]) begin
            acc_r <= acc_r + inc_s;
         end
         case (state_r)
            IDLE: begin
               if (start && (len != LEN_ZERO)) begin
                  len_r     <= len;
                  cnt_r     <= LEN_ZERO;
                  idx_r     <= IDX_ZERO;
                  acc_r     <= ACC_W'($signed(cin));
                  ain_ready <= 1'b1;
                  busy      <= 1'b1;
                  state_r   <= RUN;
               end
            end
            RUN: begin
               if (accept_s) begin
                  idx_r <= idx_r + IDX_ONE;
                  cnt_r <= cnt_r + LEN_ONE;
                  if ((cnt_r + LEN_ONE) == len_r) begin
                     ain_ready <= 1'b0;
                     state_r   <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // The oldest stage may still be folding into acc on this edge.
               if (pv_r[PIPE_DEPTH-2:0] == {(PIPE_DEPTH-1){1'b0}}) begin
                  state_r <= DONE;
               end
            end
            DONE: begin
               dout    <= result_s;
               dvalid  <= 1'b1;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               ain_ready <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_my_pe_fx.sv
// Scoreboard bench for my_pe_fx: stimulus pushes expected results, a monitor pops on dvalid.
module tb_my_pe_fx;

   localparam int DW    = 32;
   localparam int FRAC  = 8;
   localparam int LR    = 6;
   localparam int ACC_W = 48;

   logic          aclk = 1'b0;
   logic          areset;
   logic          we;
   logic [LR-1:0] waddr;
   logic [DW-1:0] wdata;
   logic          start;
   logic [LR:0]   len;
   logic [DW-1:0] cin;
   logic [DW-1:0] ain;
   logic          ain_valid;
   logic          ain_ready;
   logic          busy;
   logic [DW-1:0] dout;
   logic          dvalid;

   typedef struct {
      logic [DW-1:0] val;
      bit            lat;
      string         name;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   n_acc = 0;

   my_pe_fx #(.DW(DW), .FRAC(FRAC), .L_RAM_SIZE(LR), .ACC_W(ACC_W)) dut (
      .aclk(aclk), .areset(areset), .we(we), .waddr(waddr), .wdata(wdata),
      .start(start), .len(len), .cin(cin), .ain(ain), .ain_valid(ain_valid),
      .ain_ready(ain_ready), .busy(busy), .dout(dout), .dvalid(dvalid)
   );

   always #5 aclk = ~aclk;

   // Cycle counter and accept tracker (value of cyc after the accepting edge).
   always @(posedge aclk) begin
      cyc <= cyc + 1;
      if (ain_valid && ain_ready) begin
         last_acc <= cyc + 1;
         n_acc    <= n_acc + 1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever the DUT presents a result.
   initial begin
      exp_t e;
      forever begin
         @(negedge aclk);
         if (dvalid === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_dvalid", {63'd0, dvalid}, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk(e.name, {32'd0, dout}, {32'd0, e.val});
               if (e.lat) chk("dvalid_latency", 64'(cyc - last_acc), 64'd4);
            end
         end
      end
   end

   task automatic wr(input logic [LR-1:0] a, input logic [DW-1:0] d);
      @(negedge aclk);
      we = 1'b1; waddr = a; wdata = d;
      @(negedge aclk);
      we = 1'b0;
   endtask

   task automatic wait_idle();
      int lim;
      lim = 0;
      while (busy && lim < 100) begin
         @(negedge aclk);
         lim++;
      end
      chk("idle_timeout", {63'd0, busy}, 64'd0);
      repeat (2) @(negedge aclk);
   endtask

   // mode 0: back-to-back valid; mode 1: valid pattern 1,0,0 repeating plus trailing valids.
   task automatic run(input int n, input logic [DW-1:0] c, input logic [DW-1:0] a, input int mode,
                      input int stop_after, input bit intrude, input logic [DW-1:0] exp,
                      input bit lat, input string nm);
      exp_t e;
      int i, k, target, acc0;
      e.val = exp; e.lat = lat; e.name = nm;
      if (stop_after < 0) sb_q.push_back(e);
      target = (stop_after < 0) ? n : stop_after;
      acc0 = n_acc;
      @(negedge aclk);
      start = 1'b1; len = (LR+1)'(n); cin = c;
      @(negedge aclk);
      start = 1'b0;
      i = 0; k = 0;
      while (i < target && k < 200) begin
         ain = a;
         ain_valid = (mode == 0) ? 1'b1 : ((k % 3) == 0);
         if (intrude && k == 0) begin
            we = 1'b1; waddr = '0; wdata = '0; start = 1'b1; len = 7'd1;
         end else begin
            we = 1'b0; start = 1'b0;
         end
         if (ain_valid && ain_ready) i++;
         k++;
         @(negedge aclk);
      end
      we = 1'b0; start = 1'b0;
      chk({nm, "_accept_timeout"}, 64'(i), 64'(target));
      if (mode == 1) begin
         repeat (3) begin
            ain_valid = 1'b1;
            chk("ready_after_last", {63'd0, ain_ready}, 64'd0);
            @(negedge aclk);
         end
         chk("accept_count", 64'(n_acc - acc0), 64'(n));
      end
      ain_valid = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] exp4;
`ifdef PE_SATURATE_EN
      exp4 = 32'h7FFF_FFFF;
`else
      exp4 = 32'hFFFF_FC00;
`endif
      areset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; start = 1'b0;
      len = '0; cin = '0; ain = '0; ain_valid = 1'b0;
      repeat (3) @(negedge aclk);
      chk("rst_busy",  {63'd0, busy}, 64'd0);
      chk("rst_ready", {63'd0, ain_ready}, 64'd0);
      chk("rst_dvalid", {63'd0, dvalid}, 64'd0);
      chk("rst_dout",  {32'd0, dout}, 64'd0);
      areset = 1'b0;

      wr(6'd0, 32'd256); wr(6'd1, 32'd512); wr(6'd2, 32'd768); wr(6'd3, 32'd1024);
      run(4, 32'd0, 32'd256, 0, -1, 1'b0, 32'd2560, 1'b1, "t1_dot");
      wait_idle();
      run(4, 32'd0, 32'd256, 1, -1, 1'b0, 32'd2560, 1'b0, "t2_gaps");
      wait_idle();

      wr(6'd0, 32'hFFFF_FE00);
      run(1, 32'd256, 32'd768, 0, -1, 1'b0, 32'hFFFF_FB00, 1'b1, "t3_neg");
      wait_idle();

      wr(6'd0, 32'h7FFF_FF00);
      run(1, 32'd0, 32'h400, 0, -1, 1'b0, exp4, 1'b1, "t4_ovf");
      wait_idle();

      wr(6'd0, 32'd256);
      run(4, 32'd0, 32'd256, 0, 2, 1'b0, 32'd0, 1'b0, "t5_abort");
      areset = 1'b1;
      @(negedge aclk);
      areset = 1'b0;
      chk("abort_busy",  {63'd0, busy}, 64'd0);
      chk("abort_dout",  {32'd0, dout}, 64'd0);
      chk("abort_ready", {63'd0, ain_ready}, 64'd0);
      repeat (8) @(negedge aclk);
      run(4, 32'd0, 32'd256, 0, -1, 1'b0, 32'd2560, 1'b1, "t5_rerun");
      wait_idle();

      run(4, 32'd0, 32'd256, 0, -1, 1'b1, 32'd2560, 1'b1, "t6_intrude");
      wait_idle();
      run(1, 32'd0, 32'd256, 0, -1, 1'b0, 32'd256, 1'b1, "t6_peram0_kept");
      wait_idle();

      @(negedge aclk);
      start = 1'b1; len = '0; cin = 32'd5;
      @(negedge aclk);
      start = 1'b0;
      repeat (3) @(negedge aclk);
      chk("len0_busy",  {63'd0, busy}, 64'd0);
      chk("len0_ready", {63'd0, ain_ready}, 64'd0);

      repeat (6) @(negedge aclk);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
